// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the two result producers, the arbiter, and the CDB consumers.
// master = producers/consumers side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 alu_valid;
  logic [ROB_WIDTH-1:0] alu_rob_index;
  logic [31:0]          alu_val;
  logic                 alu_actual_br;
  logic [31:0]          alu_pc_jump;
  logic                 alu_full;
  logic                 lsb_valid;
  logic [ROB_WIDTH-1:0] lsb_rob_index;
  logic [31:0]          lsb_val;
  logic                 lsb_full;
  logic                 cdb_valid;
  logic                 cdb_src;
  logic [ROB_WIDTH-1:0] cdb_rob_index;
  logic [31:0]          cdb_val;
  logic                 cdb_actual_br;
  logic [31:0]          cdb_pc_jump;

  modport master (
    output alu_valid, alu_rob_index, alu_val, alu_actual_br, alu_pc_jump,
    output lsb_valid, lsb_rob_index, lsb_val,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_src, cdb_rob_index, cdb_val, cdb_actual_br, cdb_pc_jump
  );

  modport slave (
    input  alu_valid, alu_rob_index, alu_val, alu_actual_br, alu_pc_jump,
    input  lsb_valid, lsb_rob_index, lsb_val,
    output alu_full, lsb_full,
    output cdb_valid, cdb_src, cdb_rob_index, cdb_val, cdb_actual_br, cdb_pc_jump
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Single common data bus: ALU and LSB results are queued in per-source FIFOs and
// a round-robin arbiter broadcasts at most one registered entry per cycle.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  cdb_arbiter_if.slave     bus
);
  localparam int DEPTH = 2 ** FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH:0]   CNT_FULL = (FIFO_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = FIFO_WIDTH'(1);

  typedef struct packed {
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          val;
    logic                 br;
    logic [31:0]          jmp;
  } alu_ent_t;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          val;
  } lsb_ent_t;

  alu_ent_t              r_alu_mem [DEPTH];
  lsb_ent_t              r_lsb_mem [DEPTH];
  logic [FIFO_WIDTH-1:0] r_alu_rd, r_alu_wr, r_lsb_rd, r_lsb_wr;
  logic [FIFO_WIDTH:0]   r_alu_cnt, r_lsb_cnt;
  logic                  r_prio_lsb;

  logic                  r_cdb_valid;
  logic                  r_cdb_src;
  logic [ROB_WIDTH-1:0]  r_cdb_tag;
  logic [31:0]           r_cdb_val;
  logic                  r_cdb_br;
  logic [31:0]           r_cdb_jmp;

  logic     w_alu_full, w_lsb_full, w_alu_empty, w_lsb_empty;
  logic     w_alu_push, w_lsb_push, w_gnt_alu, w_gnt_lsb;
  alu_ent_t w_alu_head;
  lsb_ent_t w_lsb_head;

  // Full is a registered decode, so a full FIFO refuses a push even while it is popped.
  assign w_alu_full  = (r_alu_cnt == CNT_FULL);
  assign w_lsb_full  = (r_lsb_cnt == CNT_FULL);
  assign w_alu_empty = (r_alu_cnt == '0);
  assign w_lsb_empty = (r_lsb_cnt == '0);
  assign w_alu_push  = bus.alu_valid & ~w_alu_full;
  assign w_lsb_push  = bus.lsb_valid & ~w_lsb_full;
  assign w_gnt_alu   = ~w_alu_empty & (w_lsb_empty | ~r_prio_lsb);
  assign w_gnt_lsb   = ~w_lsb_empty & (w_alu_empty |  r_prio_lsb);
  assign w_alu_head  = r_alu_mem[r_alu_rd];
  assign w_lsb_head  = r_lsb_mem[r_lsb_rd];

  always_ff @(posedge clk_in) begin
    if (rdy_in && !clr_in && w_alu_push)
      r_alu_mem[r_alu_wr] <= {bus.alu_rob_index, bus.alu_val, bus.alu_actual_br, bus.alu_pc_jump};
    if (rdy_in && !clr_in && w_lsb_push)
      r_lsb_mem[r_lsb_wr] <= {bus.lsb_rob_index, bus.lsb_val};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_alu_rd    <= '0;
      r_alu_wr    <= '0;
      r_alu_cnt   <= '0;
      r_lsb_rd    <= '0;
      r_lsb_wr    <= '0;
      r_lsb_cnt   <= '0;
      r_prio_lsb  <= 1'b0;
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_val   <= '0;
      r_cdb_br    <= 1'b0;
      r_cdb_jmp   <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        r_alu_rd    <= '0;
        r_alu_wr    <= '0;
        r_alu_cnt   <= '0;
        r_lsb_rd    <= '0;
        r_lsb_wr    <= '0;
        r_lsb_cnt   <= '0;
        r_prio_lsb  <= 1'b0;
        r_cdb_valid <= 1'b0;
      end else begin
        if (w_alu_push) r_alu_wr <= r_alu_wr + PTR_ONE;
        if (w_lsb_push) r_lsb_wr <= r_lsb_wr + PTR_ONE;
        if (w_gnt_alu)  r_alu_rd <= r_alu_rd + PTR_ONE;
        if (w_gnt_lsb)  r_lsb_rd <= r_lsb_rd + PTR_ONE;

        if (w_alu_push && !w_gnt_alu)      r_alu_cnt <= r_alu_cnt + CNT_ONE;
        else if (!w_alu_push && w_gnt_alu) r_alu_cnt <= r_alu_cnt - CNT_ONE;
        if (w_lsb_push && !w_gnt_lsb)      r_lsb_cnt <= r_lsb_cnt + CNT_ONE;
        else if (!w_lsb_push && w_gnt_lsb) r_lsb_cnt <= r_lsb_cnt - CNT_ONE;

        if (w_gnt_alu) begin
          r_cdb_valid <= 1'b1;
          r_cdb_src   <= 1'b0;
          r_cdb_tag   <= w_alu_head.tag;
          r_cdb_val   <= w_alu_head.val;
          r_cdb_br    <= w_alu_head.br;
          r_cdb_jmp   <= w_alu_head.jmp;
          r_prio_lsb  <= 1'b1;
        end else if (w_gnt_lsb) begin
          r_cdb_valid <= 1'b1;
          r_cdb_src   <= 1'b1;
          r_cdb_tag   <= w_lsb_head.tag;
          r_cdb_val   <= w_lsb_head.val;
          r_cdb_br    <= 1'b0;
          r_cdb_jmp   <= '0;
          r_prio_lsb  <= 1'b0;
        end else begin
          r_cdb_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.alu_full      = w_alu_full;
  assign bus.lsb_full      = w_lsb_full;
  assign bus.cdb_valid     = r_cdb_valid;
  assign bus.cdb_src       = r_cdb_src;
  assign bus.cdb_rob_index = r_cdb_tag;
  assign bus.cdb_val       = r_cdb_val;
  assign bus.cdb_actual_br = r_cdb_br;
  assign bus.cdb_pc_jump   = r_cdb_jmp;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for contention/full/latency,
// then hand sequences for flush, freeze and asynchronous reset.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n, rdy, clr;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.ROB_WIDTH(4)) bus ();

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(2)) u_dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clr_in   (clr),
    .bus      (bus)
  );

  typedef struct {
    logic        rdy, clr, av, lv;
    logic [3:0]  at, lt;
    logic [72:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Payloads are derived from the tag so each broadcast is identifiable; tag 3 -> 0x1234/br=1/0x100.
  function automatic logic [31:0] aval(input logic [3:0] t);
    return 32'h1231 + 32'(t);
  endfunction
  function automatic logic [31:0] ajmp(input logic [3:0] t);
    return (32'(t) - 32'd2) << 8;
  endfunction
  function automatic logic [31:0] lval(input logic [3:0] t);
    return 32'hB000_0000 | 32'(t);
  endfunction

  // es: -1 = all fields zero, 0 = ALU entry with tag et, 1 = LSB entry with tag et.
  function automatic logic [72:0] exp_of(input logic ev, input int es, input logic [3:0] et,
                                         input logic af, input logic lf);
    if (es < 0)  return {ev, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, af, lf};
    if (es == 0) return {ev, 1'b0, et, aval(et), et[0], ajmp(et), af, lf};
    return {ev, 1'b1, et, lval(et), 1'b0, 32'h0, af, lf};
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic av, input int at,
                              input logic lv, input int lt, input logic ev, input int es,
                              input int et, input logic af, input logic lf);
    vec_t v;
    v.rdy = r; v.clr = c; v.av = av; v.lv = lv;
    v.at  = 4'(at); v.lt = 4'(lt);
    v.exp = exp_of(ev, es, 4'(et), af, lf);
    return v;
  endfunction

  function automatic logic [72:0] outs();
    return {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index, bus.cdb_val,
            bus.cdb_actual_br, bus.cdb_pc_jump, bus.alu_full, bus.lsb_full};
  endfunction

  task automatic check(input string name, input logic [72:0] exp);
    logic [72:0] got;
    got = outs();
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy               = v.rdy;
    clr               = v.clr;
    bus.alu_valid     = v.av;
    bus.alu_rob_index = v.at;
    bus.alu_val       = aval(v.at);
    bus.alu_actual_br = v.at[0];
    bus.alu_pc_jump   = ajmp(v.at);
    bus.lsb_valid     = v.lv;
    bus.lsb_rob_index = v.lt;
    bus.lsb_val       = lval(v.lt);
  endtask

  task automatic apply(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.exp);
  endtask

  initial begin
    // Contention: both sources push for 8 cycles; drops when full, alternating grants.
    vecs.push_back(mk(1,0,1,1,1,9,   0,-1,0,  0,0));
    vecs.push_back(mk(1,0,1,2,1,10,  1,0,1,   0,0));
    vecs.push_back(mk(1,0,1,3,1,11,  1,1,9,   0,0));
    vecs.push_back(mk(1,0,1,4,1,12,  1,0,2,   0,0));
    vecs.push_back(mk(1,0,1,5,1,13,  1,1,10,  0,0));
    vecs.push_back(mk(1,0,1,6,1,14,  1,0,3,   0,1));
    vecs.push_back(mk(1,0,1,7,1,15,  1,1,11,  1,0));
    vecs.push_back(mk(1,0,1,8,1,1,   1,0,4,   0,1));
    vecs.push_back(mk(1,0,0,0,0,0,   1,1,12,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,5,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,1,13,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,6,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,1,14,  0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,7,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,1,1,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   0,1,1,   0,0));
    // Single uncontended ALU push: two-cycle latency, one-cycle pulse.
    vecs.push_back(mk(1,0,1,3,0,0,   0,1,1,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,3,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   0,0,3,   0,0));
    // ALU fills while sharing the bus with LSB (priority LSB); ALU tag 7 is dropped.
    vecs.push_back(mk(1,0,1,1,1,2,   0,0,3,   0,0));
    vecs.push_back(mk(1,0,1,2,1,3,   1,1,2,   0,0));
    vecs.push_back(mk(1,0,1,3,1,4,   1,0,1,   0,0));
    vecs.push_back(mk(1,0,1,4,1,5,   1,1,3,   0,0));
    vecs.push_back(mk(1,0,1,5,0,0,   1,0,2,   0,0));
    vecs.push_back(mk(1,0,1,6,0,0,   1,1,4,   1,0));
    vecs.push_back(mk(1,0,1,7,0,0,   1,0,3,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,1,5,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,4,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,5,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   1,0,6,   0,0));
    vecs.push_back(mk(1,0,0,0,0,0,   0,0,6,   0,0));

    rst_n = 1'b0;
    drive(mk(1,0,0,0,0,0, 0,-1,0, 0,0));
    #3;
    check("reset_state", exp_of(1'b0, -1, 4'h0, 1'b0, 1'b0));
    #9;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Flush with both FIFOs at 3 entries plus simultaneous pushes; priority returns to ALU.
    apply("clr_fill0", mk(1,0,1,1,1,1,  0,0,6,  0,0));
    apply("clr_fill1", mk(1,0,1,2,1,2,  1,1,1,  0,0));
    apply("clr_fill2", mk(1,0,1,3,1,3,  1,0,1,  0,0));
    apply("clr_fill3", mk(1,0,1,4,1,4,  1,1,2,  0,0));
    apply("clr_fill4", mk(1,0,1,5,1,5,  1,0,2,  0,0));
    apply("clr_flush", mk(1,1,1,6,1,6,  0,0,2,  0,0));
    apply("clr_idle0", mk(1,0,0,0,0,0,  0,0,2,  0,0));
    apply("clr_idle1", mk(1,0,0,0,0,0,  0,0,2,  0,0));
    apply("clr_push",  mk(1,0,1,7,1,7,  0,0,2,  0,0));
    apply("clr_prio0", mk(1,0,0,0,0,0,  1,0,7,  0,0));
    apply("clr_prio1", mk(1,0,0,0,0,0,  1,1,7,  0,0));
    apply("clr_prio2", mk(1,0,0,0,0,0,  0,1,7,  0,0));

    // Freeze for 3 cycles with toggling inputs; priority LSB must survive.
    apply("rdy_fill0", mk(1,0,1,8,1,8,   0,1,7,  0,0));
    apply("rdy_fill1", mk(1,0,1,9,1,9,   1,0,8,  0,0));
    apply("rdy_frz0",  mk(0,0,1,10,0,0,  1,0,8,  0,0));
    apply("rdy_frz1",  mk(0,1,0,0,1,10,  1,0,8,  0,0));
    apply("rdy_frz2",  mk(0,0,1,11,1,11, 1,0,8,  0,0));
    apply("rdy_res0",  mk(1,0,0,0,0,0,   1,1,8,  0,0));
    apply("rdy_res1",  mk(1,0,0,0,0,0,   1,0,9,  0,0));
    apply("rdy_res2",  mk(1,0,0,0,0,0,   1,1,9,  0,0));
    apply("rdy_res3",  mk(1,0,0,0,0,0,   0,1,9,  0,0));

    // Asynchronous reset mid-burst with cdb_valid high and entries still queued.
    apply("rst_burst0", mk(1,0,1,11,1,11, 0,1,9,  0,0));
    apply("rst_burst1", mk(1,0,1,12,0,0,  1,0,11, 0,0));
    drive(mk(1,0,0,0,0,0, 0,-1,0, 0,0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", exp_of(1'b0, -1, 4'h0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("rst_hold", exp_of(1'b0, -1, 4'h0, 1'b0, 1'b0));
    rst_n = 1'b1;
    apply("rst_empty0", mk(1,0,0,0,0,0, 0,-1,0, 0,0));
    apply("rst_empty1", mk(1,0,0,0,0,0, 0,-1,0, 0,0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
